pipe_credit_fifo: RTL and testbench

Credit-based elastic buffer that sits directly downstream of a fixed-latency `pipeline` stage. The pipeline cannot stall, so this block hands out issue credits to the upstream producer and guarantees buffer space for every sample in flight. It captures the pipeline output into a small FIFO and presents it to a valid/ready consumer with first-word-fall-through semantics.

---
 rtl/pipe_credit_fifo.sv | 57 +++++
 tb/tb_pipe_credit_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_credit_fifo.sv
// pipe_credit_fifo: credit-issuing FWFT FIFO behind a non-stallable pipeline.
// Define PIPE_CREDIT_FIFO_ERR_EN to build the sticky err_out protocol checker.
module pipe_credit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  output logic                       issue_ready_out,
  input  logic                       issue_in,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       valid_out,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       err_out
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] credits, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic issue, pop, push, full;
  assign issue_ready_out = credits != '0;
  assign valid_out = count != '0;
  assign data_out = valid_out ? mem[rd_ptr] : '0;
  assign count_out = count;
  assign full = count == CW'(DEPTH);
  assign issue = issue_in & issue_ready_out;
  assign pop = valid_out & ready_in;
  // a pop frees the slot the same cycle, so a full FIFO can still accept
  assign push = valid_in & (~full | pop);
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      credits <= CW'(DEPTH);
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      credits <= issue & ~pop ? credits - CW'(1) : pop & ~issue ? credits + CW'(1) : credits;
      count <= push & ~pop ? count + CW'(1) : pop & ~push ? count - CW'(1) : count;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= data_in;
`ifdef PIPE_CREDIT_FIFO_ERR_EN
  logic err;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) err <= 1'b0;
    else if ((issue_in & ~issue_ready_out) | (valid_in & full & ~pop)) err <= 1'b1;
  assign err_out = err;
`else
  assign err_out = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_credit_fifo.sv
// tb_pipe_credit_fifo: directed bench with a 4-stage pipeline and a queue-based reference model.
module tb_pipe_credit_fifo;
`ifdef PIPE_CREDIT_FIFO_ERR_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif
  logic clk, rst, issue_ready_out, issue_in, valid_in, valid_out, ready_in, err_out;
  logic [15:0] data_in, data_out, issue_data, inj_d;
  logic [3:0] count_out;
  logic inj_v;
  logic [3:0] pv;
  logic [15:0] pd [4];
  int errors = 0, checks = 0;
  bit go = 0;
  logic [15:0] log_q [$];
  int m_cred = 8;
  logic [15:0] m_q [$];
  bit m_err = 0, m_pop, m_push, m_iss;

  pipe_credit_fifo #(.WIDTH(16), .DEPTH(8)) dut (
    .clk_in(clk), .rst_in(rst), .issue_ready_out(issue_ready_out), .issue_in(issue_in),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out), .data_out(data_out),
    .ready_in(ready_in), .count_out(count_out), .err_out(err_out));

  initial clk = 0;
  always #5 clk = ~clk;

  // upstream pipeline: only samples the credit logic actually issued enter it
  always @(posedge clk or posedge rst)
    if (rst) pv <= '0;
    else begin
      pv <= {pv[2:0], issue_in & issue_ready_out};
      pd[0] <= issue_data;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
  assign valid_in = pv[3] | inj_v;
  assign data_in = inj_v ? inj_d : pd[3];

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_cred = 8;
      m_q.delete();
      m_err = 0;
    end else begin
      m_iss = issue_in && m_cred != 0;
      m_pop = m_q.size() != 0 && ready_in;
      m_push = valid_in && (m_q.size() < 8 || m_pop);
      if (ERR_EXP && ((issue_in && m_cred == 0) || (valid_in && m_q.size() == 8 && !m_pop))) m_err = 1;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(data_in);
      m_cred += int'(m_pop) - int'(m_iss);
    end

  always @(posedge clk)
    if (!rst && valid_out && ready_in) log_q.push_back(data_out);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (go) begin
      chk("issue_ready", 32'(issue_ready_out), 32'(m_cred != 0));
      chk("valid", 32'(valid_out), 32'(m_q.size() != 0));
      chk("data", 32'(data_out), m_q.size() != 0 ? 32'(m_q[0]) : 32'd0);
      chk("count", 32'(count_out), 32'(m_q.size()));
      chk("err", 32'(err_out), 32'(m_err));
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] base, output int acc);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      issue_in = 1;
      issue_data = base + 16'(k);
      if (issue_ready_out) acc++;
      cyc();
    end
    issue_in = 0;
    repeat (5) cyc();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("rst_issue_ready", 32'(issue_ready_out), 1);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_count", 32'(count_out), 0);
    chk("rst_err", 32'(err_out), 0);
    cyc();
    rst = 0;
  endtask

  function automatic int order_bad(input logic [15:0] base, input int n);
    int b = (log_q.size() != n) ? 1 : 0;
    for (int i = 0; i < log_q.size() && i < n; i++)
      if (log_q[i] !== base + 16'(i)) b++;
    return b;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, n, low;
    bit fired;
    logic [63:0] pat = 64'hB53C96E17A0FD24B;
    rst = 1; issue_in = 0; issue_data = 0; ready_in = 0; inj_v = 0; inj_d = 0;
    repeat (2) cyc();
    chk("init_issue_ready", 32'(issue_ready_out), 1);
    chk("init_valid", 32'(valid_out), 0);
    chk("init_data", 32'(data_out), 0);
    chk("init_count", 32'(count_out), 0);
    chk("init_err", 32'(err_out), 0);
    rst = 0;
    go = 1;
    // fill then drain
    fill(16'h0001, acc);
    chk("credits_accepted", 32'(acc), 8);
    chk("full_issue_ready", 32'(issue_ready_out), 0);
    chk("full_count", 32'(count_out), 8);
    chk("full_head", 32'(data_out), 32'h0001);
    log_q.delete();
    ready_in = 1;
    repeat (8) cyc();
    ready_in = 0;
    chk("drain_count", 32'(count_out), 0);
    chk("drain_order", 32'(order_bad(16'h0001, 8)), 0);
    chk("drain_issue_ready", 32'(issue_ready_out), 1);
    // streaming
    log_q.delete();
    low = 0;
    issue_in = 1;
    ready_in = 1;
    for (int i = 0; i < 100; i++) begin
      issue_data = 16'(100 + i);
      if (!issue_ready_out) low++;
      cyc();
    end
    issue_in = 0;
    repeat (10) cyc();
    ready_in = 0;
    chk("stream_no_stall", 32'(low), 0);
    chk("stream_order", 32'(order_bad(16'd100, 100)), 0);
    // simultaneous push and pop while full
    fill(16'h0040, acc);
    log_q.delete();
    inj_v = 1; inj_d = 16'h00AA; ready_in = 1;
    cyc();
    inj_v = 0; ready_in = 0;
    chk("pp_count", 32'(count_out), 8);
    chk("pp_head", 32'(data_out), 32'h0041);
    ready_in = 1;
    repeat (8) cyc();
    ready_in = 0;
    chk("pp_popped", 32'(log_q.size()), 9);
    chk("pp_tail", log_q.size() == 9 ? 32'(log_q[8]) : 32'hFFFF, 32'h00AA);
    // reset while holding data
    do_reset();
    fill(16'h0050, acc);
    do_reset();
    // wrap-around with stalls
    log_q.delete();
    n = 0;
    for (int i = 0; i < 300 && log_q.size() < 20; i++) begin
      issue_in = n < 20;
      issue_data = 16'(n);
      ready_in = pat[i % 64];
      fired = issue_in && issue_ready_out;
      cyc();
      if (fired) n++;
    end
    issue_in = 0; ready_in = 0;
    chk("wrap_order", 32'(order_bad(16'd0, 20)), 0);
    // issue with zero credits
    do_reset();
    fill(16'h0010, acc);
    issue_in = 1;
    cyc();
    issue_in = 0;
    chk("err_issue", 32'(err_out), 32'(ERR_EXP));
    chk("err_issue_count", 32'(count_out), 8);
    cyc();
    chk("err_issue_sticky", 32'(err_out), 32'(ERR_EXP));
    // overflow push
    do_reset();
    fill(16'h0020, acc);
    chk("pre_ovf_err", 32'(err_out), 0);
    inj_v = 1; inj_d = 16'h00BB;
    cyc();
    inj_v = 0;
    chk("err_ovf", 32'(err_out), 32'(ERR_EXP));
    chk("ovf_count", 32'(count_out), 8);
    chk("ovf_head", 32'(data_out), 32'h0020);
    log_q.delete();
    ready_in = 1;
    repeat (8) cyc();
    ready_in = 0;
    chk("ovf_dropped", 32'(order_bad(16'h0020, 8)), 0);
    chk("err_ovf_sticky", 32'(err_out), 32'(ERR_EXP));
    go = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
